// File: rtl/calc_sched_pkg.sv
// Shared constants, state/unit enums and command decode helpers for the
// calc operation scheduler.
package calc_sched_pkg;

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned RESP_W = 2;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_LSH = 4'd5;
  localparam logic [CMD_W-1:0] CMD_RSH = 4'd6;

  localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
  localparam logic [RESP_W-1:0] RESP_SUCC = 2'd1;
  localparam logic [RESP_W-1:0] RESP_INOF = 2'd2;
  localparam logic [RESP_W-1:0] RESP_IERR = 2'd3;

  typedef enum logic [1:0] {IDLE, OP2, QUEUED, RESP} port_state_t;
  typedef enum logic {UNIT_ARITH, UNIT_SHIFT} unit_t;

  // Command is one the datapath can execute.
  function automatic logic cmd_valid(input logic [CMD_W-1:0] c);
    return (c == CMD_ADD) || (c == CMD_SUB) || (c == CMD_LSH) || (c == CMD_RSH);
  endfunction

  // Which shared unit serves a valid command.
  function automatic unit_t cmd_unit(input logic [CMD_W-1:0] c);
    return ((c == CMD_LSH) || (c == CMD_RSH)) ? UNIT_SHIFT : UNIT_ARITH;
  endfunction

endpackage

// File: rtl/calc_op_scheduler_if.sv
// Calc request/response bundle for all ports.
//   req_cmd_in  : per-port 4-bit command, port p at [4p+3:4p]
//   req_data_in : per-port operand (op1 with cmd, op2 the next cycle)
//   out_resp    : per-port 2-bit response
//   out_data    : per-port result
//   busy        : port has a command in flight
//   proto_err   : sticky per-port protocol error
// master = requester side, slave = scheduler side.
interface calc_op_scheduler_if
  import calc_sched_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DW        = 32
);

  logic [CMD_W*NUM_PORTS-1:0]  req_cmd_in;
  logic [DW*NUM_PORTS-1:0]     req_data_in;
  logic [RESP_W*NUM_PORTS-1:0] out_resp;
  logic [DW*NUM_PORTS-1:0]     out_data;
  logic [NUM_PORTS-1:0]        busy;
  logic [NUM_PORTS-1:0]        proto_err;

  modport master (
    output req_cmd_in, req_data_in,
    input  out_resp, out_data, busy, proto_err
  );

  modport slave (
    input  req_cmd_in, req_data_in,
    output out_resp, out_data, busy, proto_err
  );

endinterface

// File: rtl/calc_sched_fifo.sv
// Port-index FIFO feeding one shared unit.
//   clk, reset : clock, synchronous active-high reset
//   push       : one bit per port; same-cycle pushes enqueue in ascending port order
//   pop        : remove head (ignored while empty)
//   head       : port index at the head
//   empty      : no entry queued
//   push_err   : per-port push that found the queue full
module calc_sched_fifo #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned IW        = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] push,
  input  logic                 pop,
  output logic [IW-1:0]        head,
  output logic                 empty,
  output logic [NUM_PORTS-1:0] push_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] mem_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;

  // Pop shifts the array down first so a freed slot is usable by this cycle's pushes.
  always_comb begin
    mem_d    = mem_q;
    cnt_d    = cnt_q;
    push_err = '0;
    if (pop && (cnt_q != '0)) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
      cnt_d          = cnt_q - CW'(1);
    end
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (push[p]) begin
        if (cnt_d < CW'(DEPTH)) begin
          mem_d[IW'(cnt_d)] = IW'(p);
          cnt_d             = cnt_d + CW'(1);
        end else begin
          push_err[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

  assign head  = mem_q[0];
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/calc_op_scheduler.sv
// Multi-port calc command scheduler sharing one add/sub unit and one shift
// unit across NUM_PORTS two-cycle request ports.
//   c_clk : clock, rising edge
//   reset : synchronous, active-high
//   bus   : calc_op_scheduler_if.slave (requests in, responses/status out)
// Optional build macro CALC_SCHED_PROTO_CHK_EN: flags a command arriving on a
// port in OP2/QUEUED as a sticky proto_err; otherwise proto_err is tied low.
module calc_op_scheduler
  import calc_sched_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DW        = 32
) (
  input  logic                c_clk,
  input  logic                reset,
  calc_op_scheduler_if.slave  bus
);

  localparam int unsigned IW  = $clog2(NUM_PORTS);
  localparam int unsigned SHW = $clog2(DW);
  localparam int unsigned RW  = RESP_W + DW;

  logic [CMD_W-1:0]     cmd_in  [NUM_PORTS];
  logic [DW-1:0]        data_in [NUM_PORTS];

  port_state_t          state_q [NUM_PORTS];
  port_state_t          state_d [NUM_PORTS];
  logic [CMD_W-1:0]     cmd_q   [NUM_PORTS];
  logic [CMD_W-1:0]     cmd_d   [NUM_PORTS];
  logic [DW-1:0]        op1_q   [NUM_PORTS];
  logic [DW-1:0]        op1_d   [NUM_PORTS];
  logic [DW-1:0]        op2_q   [NUM_PORTS];
  logic [DW-1:0]        op2_d   [NUM_PORTS];
  logic [RESP_W-1:0]    resp_q  [NUM_PORTS];
  logic [RESP_W-1:0]    resp_d  [NUM_PORTS];
  logic [DW-1:0]        data_q  [NUM_PORTS];
  logic [DW-1:0]        data_d  [NUM_PORTS];
  logic [NUM_PORTS-1:0] busy_q, busy_d;
`ifdef CALC_SCHED_PROTO_CHK_EN
  logic [NUM_PORTS-1:0] proto_q, proto_d;
`endif

  logic [NUM_PORTS-1:0] push_arith, push_shift;
  logic [NUM_PORTS-1:0] perr_arith, perr_shift;
  logic [IW-1:0]        head_arith, head_shift;
  logic                 empty_arith, empty_shift;
  logic                 gnt_arith, gnt_shift;
  logic [RW-1:0]        res_arith, res_shift;

  // Flat bus <-> per-port views.
  for (genvar g = 0; g < int'(NUM_PORTS); g++) begin : g_port_io
    assign cmd_in[g]  = bus.req_cmd_in[CMD_W*g +: CMD_W];
    assign data_in[g] = bus.req_data_in[DW*g +: DW];
    assign bus.out_resp[RESP_W*g +: RESP_W] = resp_q[g];
    assign bus.out_data[DW*g +: DW]         = data_q[g];
  end
  assign bus.busy = busy_q;
`ifdef CALC_SCHED_PROTO_CHK_EN
  assign bus.proto_err = proto_q;
`else
  assign bus.proto_err = '0;
`endif

  // Add/sub: unsigned, carry-out or borrow reports INOF with zero data.
  function automatic logic [RW-1:0] arith_exec(input logic [CMD_W-1:0] c,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    logic [DW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (c == CMD_ADD) begin
      if (sum[DW]) return {RESP_INOF, DW'(0)};
      return {RESP_SUCC, sum[DW-1:0]};
    end else if (c == CMD_SUB) begin
      if (a < b) return {RESP_INOF, DW'(0)};
      return {RESP_SUCC, DW'(a - b)};
    end
    return {RESP_IERR, DW'(0)};
  endfunction

  // Shift: amount from the low log2(DW) bits of op2, zero fill.
  function automatic logic [RW-1:0] shift_exec(input logic [CMD_W-1:0] c,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    if (c == CMD_LSH) return {RESP_SUCC, DW'(a << b[SHW-1:0])};
    if (c == CMD_RSH) return {RESP_SUCC, DW'(a >> b[SHW-1:0])};
    return {RESP_IERR, DW'(0)};
  endfunction

  // Enqueue in the OP2 cycle so a port is granted no earlier than the next cycle.
  always_comb begin
    push_arith = '0;
    push_shift = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if ((state_q[p] == OP2) && cmd_valid(cmd_q[p])) begin
        if (cmd_unit(cmd_q[p]) == UNIT_SHIFT) push_shift[p] = 1'b1;
        else                                  push_arith[p] = 1'b1;
      end
    end
  end

  assign gnt_arith = !empty_arith;
  assign gnt_shift = !empty_shift;

  calc_sched_fifo #(.NUM_PORTS(NUM_PORTS), .DEPTH(NUM_PORTS), .IW(IW)) u_fifo_arith (
    .clk      (c_clk),
    .reset    (reset),
    .push     (push_arith),
    .pop      (gnt_arith),
    .head     (head_arith),
    .empty    (empty_arith),
    .push_err (perr_arith)
  );

  calc_sched_fifo #(.NUM_PORTS(NUM_PORTS), .DEPTH(NUM_PORTS), .IW(IW)) u_fifo_shift (
    .clk      (c_clk),
    .reset    (reset),
    .push     (push_shift),
    .pop      (gnt_shift),
    .head     (head_shift),
    .empty    (empty_shift),
    .push_err (perr_shift)
  );

  // Datapaths operate on the granted port's latched operands.
  always_comb begin
    res_arith = arith_exec(cmd_q[head_arith], op1_q[head_arith], op2_q[head_arith]);
    res_shift = shift_exec(cmd_q[head_shift], op1_q[head_shift], op2_q[head_shift]);
  end

  // Per-port FSM next state and registered outputs.
  always_comb begin
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      state_d[p] = state_q[p];
      cmd_d[p]   = cmd_q[p];
      op1_d[p]   = op1_q[p];
      op2_d[p]   = op2_q[p];
      resp_d[p]  = RESP_NONE;
      data_d[p]  = '0;
`ifdef CALC_SCHED_PROTO_CHK_EN
      proto_d[p] = proto_q[p];
`endif
      case (state_q[p])
        IDLE: begin
          if (cmd_in[p] != CMD_NOP) begin
            cmd_d[p]   = cmd_in[p];
            op1_d[p]   = data_in[p];
            state_d[p] = OP2;
          end
        end
        OP2: begin
          op2_d[p] = data_in[p];
          if (!cmd_valid(cmd_q[p])) begin
            state_d[p] = RESP;
            resp_d[p]  = RESP_INOF;
          end else if (perr_arith[p] || perr_shift[p]) begin
            state_d[p] = RESP;
            resp_d[p]  = RESP_IERR;
          end else begin
            state_d[p] = QUEUED;
          end
`ifdef CALC_SCHED_PROTO_CHK_EN
          if (cmd_in[p] != CMD_NOP) proto_d[p] = 1'b1;
`endif
        end
        QUEUED: begin
          if ((cmd_unit(cmd_q[p]) == UNIT_ARITH) && gnt_arith && (head_arith == IW'(p))) begin
            state_d[p] = RESP;
            resp_d[p]  = res_arith[RW-1:DW];
            data_d[p]  = res_arith[DW-1:0];
          end else if ((cmd_unit(cmd_q[p]) == UNIT_SHIFT) && gnt_shift && (head_shift == IW'(p))) begin
            state_d[p] = RESP;
            resp_d[p]  = res_shift[RW-1:DW];
            data_d[p]  = res_shift[DW-1:0];
          end
`ifdef CALC_SCHED_PROTO_CHK_EN
          if (cmd_in[p] != CMD_NOP) proto_d[p] = 1'b1;
`endif
        end
        RESP: begin
          // A command in the response cycle starts the next operation directly.
          if (cmd_in[p] != CMD_NOP) begin
            cmd_d[p]   = cmd_in[p];
            op1_d[p]   = data_in[p];
            state_d[p] = OP2;
          end else begin
            state_d[p] = IDLE;
          end
        end
        default: state_d[p] = IDLE;
      endcase
      busy_d[p] = (state_d[p] != IDLE);
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      busy_q <= '0;
`ifdef CALC_SCHED_PROTO_CHK_EN
      proto_q <= '0;
`endif
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        state_q[p] <= IDLE;
        cmd_q[p]   <= CMD_NOP;
        op1_q[p]   <= '0;
        op2_q[p]   <= '0;
        resp_q[p]  <= RESP_NONE;
        data_q[p]  <= '0;
      end
    end else begin
      busy_q <= busy_d;
`ifdef CALC_SCHED_PROTO_CHK_EN
      proto_q <= proto_d;
`endif
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        state_q[p] <= state_d[p];
        cmd_q[p]   <= cmd_d[p];
        op1_q[p]   <= op1_d[p];
        op2_q[p]   <= op2_d[p];
        resp_q[p]  <= resp_d[p];
        data_q[p]  <= data_d[p];
      end
    end
  end

endmodule
